// File: rtl/fpnew_lane_gather_slice.sv
// fpnew_lane_gather_slice: dispatches an op to independent lane units and gathers their
// out-of-step results into one NaN-boxed result with masked status.
module fpnew_lane_gather_slice #(
    parameter int unsigned Width         = 64,
    parameter int unsigned FpWidth       = 32,
    parameter bit          EnableVectors = 1'b1,
    parameter int unsigned Depth         = 4,
    parameter int unsigned TagWidth      = 8,
    localparam int unsigned NUM_LANES    = Width / FpWidth,
    localparam int unsigned CNT_W        = $clog2(Depth + 1),
    localparam int unsigned PTR_W        = (Depth > 1) ? $clog2(Depth) : 1
) (
    input  logic                           clk_i,
    input  logic                           rst_ni,
    input  logic                           in_valid_i,
    output logic                           in_ready_o,
    input  logic                           vectorial_op_i,
    input  logic [NUM_LANES-1:0]           simd_mask_i,
    input  logic                           box_bit_i,
    input  logic [TagWidth-1:0]            tag_i,
    input  logic                           flush_i,
    output logic [NUM_LANES-1:0]           lane_valid_o,
    input  logic [NUM_LANES-1:0]           lane_ready_i,
    input  logic [NUM_LANES-1:0]           lane_out_valid_i,
    output logic [NUM_LANES-1:0]           lane_out_ready_o,
    input  logic [NUM_LANES*FpWidth-1:0]   lane_result_i,
    input  logic [NUM_LANES*5-1:0]         lane_status_i,
    output logic                           out_valid_o,
    input  logic                           out_ready_i,
    output logic [Width-1:0]               result_o,
    output logic [4:0]                     status_o,
    output logic [TagWidth-1:0]            tag_o,
    output logic                           busy_o
);

    logic [TagWidth-1:0]  tag_q  [Depth];
    logic [NUM_LANES-1:0] mask_q [Depth];
    logic [Depth-1:0]     vec_q, box_q;
    logic [PTR_W-1:0]     wr_ptr, rd_ptr;
    logic [CNT_W-1:0]     count_q;
    logic [FpWidth-1:0]   res_q  [NUM_LANES];
    logic [4:0]           stat_q [NUM_LANES];
    logic [NUM_LANES-1:0] done_q, active, head_active, head_mask, ret, owned;
    logic                 can_issue, push, pop, head_box, nonempty, complete;

    assign nonempty  = count_q != '0;
    assign head_mask = mask_q[rd_ptr];
    assign head_box  = box_q[rd_ptr];

    always_comb begin
        active      = '0;
        head_active = '0;
        for (int l = 0; l < NUM_LANES; l++) begin
            active[l]      = (l == 0) | (vectorial_op_i & EnableVectors);
            head_active[l] = (l == 0) | (vec_q[rd_ptr] & EnableVectors);
        end
    end

    // Readiness depends only on occupancy, never on this cycle's pop.
    assign can_issue    = (count_q < CNT_W'(Depth)) & ~flush_i & (&(lane_ready_i | ~active));
    assign in_ready_o   = can_issue;
    assign push         = in_valid_i & can_issue;
    assign lane_valid_o = {NUM_LANES{push}} & active;

    assign owned            = nonempty ? head_active : '0;
    assign lane_out_ready_o = flush_i ? '1 : owned & ~done_q;
    assign ret              = lane_out_valid_i & lane_out_ready_o & {NUM_LANES{~flush_i}};

    assign complete    = nonempty & ((head_active & ~done_q) == '0);
    assign out_valid_o = complete & ~flush_i;
    assign pop         = out_valid_o & out_ready_i;
    assign tag_o       = tag_q[rd_ptr];
    assign busy_o      = nonempty;

    always_comb begin
        result_o = {Width{head_box}};
        status_o = '0;
        for (int l = 0; l < NUM_LANES; l++) begin
            if (head_active[l]) result_o[l*FpWidth +: FpWidth] = res_q[l];
            status_o = status_o | (stat_q[l] & {5{head_active[l] & head_mask[l]}});
        end
    end

    function automatic logic [PTR_W-1:0] nxt(input logic [PTR_W-1:0] p);
        return (p == PTR_W'(Depth - 1)) ? '0 : p + 1'b1;
    endfunction

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            wr_ptr  <= '0;
            rd_ptr  <= '0;
            count_q <= '0;
            done_q  <= '0;
            vec_q   <= '0;
            box_q   <= '0;
            for (int d = 0; d < Depth; d++) begin
                tag_q[d]  <= '0;
                mask_q[d] <= '0;
            end
            for (int l = 0; l < NUM_LANES; l++) begin
                res_q[l]  <= '0;
                stat_q[l] <= '0;
            end
        end else if (flush_i) begin
            wr_ptr  <= '0;
            rd_ptr  <= '0;
            count_q <= '0;
            done_q  <= '0;
        end else begin
            if (push) begin
                tag_q[wr_ptr]  <= tag_i;
                mask_q[wr_ptr] <= simd_mask_i;
                vec_q[wr_ptr]  <= vectorial_op_i;
                box_q[wr_ptr]  <= box_bit_i;
                wr_ptr         <= nxt(wr_ptr);
            end
            if (pop) rd_ptr <= nxt(rd_ptr);
            count_q <= count_q + CNT_W'(push) - CNT_W'(pop);
            for (int l = 0; l < NUM_LANES; l++) begin
                if (ret[l]) begin
                    res_q[l]  <= lane_result_i[l*FpWidth +: FpWidth];
                    stat_q[l] <= lane_status_i[l*5 +: 5];
                end
            end
            done_q <= pop ? '0 : done_q | ret;
        end
    end

    // A lane offering a result that no in-flight op owns is an integration error.
    always @(posedge clk_i) begin
        if (rst_ni && !flush_i)
            assert ((lane_out_valid_i & ~owned) == '0)
            else $error("lane result offered with no owning op: %b", lane_out_valid_i);
    end

endmodule

// File: tb/tb_fpnew_lane_gather_slice.sv
// tb_fpnew_lane_gather_slice: directed checks of dispatch, gather, masking, backpressure,
// flush and reset behaviour with the bench acting as the lane units.
module tb_fpnew_lane_gather_slice;

    logic        clk_i = 1'b0;
    logic        rst_ni;
    logic        in_valid_i, in_ready_o, vectorial_op_i, box_bit_i, flush_i;
    logic [1:0]  simd_mask_i, lane_valid_o, lane_ready_i, lane_out_valid_i, lane_out_ready_o;
    logic [7:0]  tag_i, tag_o;
    logic [63:0] lane_result_i, result_o;
    logic [9:0]  lane_status_i;
    logic        out_valid_o, out_ready_i, busy_o;
    logic [4:0]  status_o;
    int          n_cmp = 0;
    int          n_err = 0;

    always #5 clk_i = ~clk_i;

    fpnew_lane_gather_slice dut (
        .clk_i(clk_i), .rst_ni(rst_ni),
        .in_valid_i(in_valid_i), .in_ready_o(in_ready_o),
        .vectorial_op_i(vectorial_op_i), .simd_mask_i(simd_mask_i),
        .box_bit_i(box_bit_i), .tag_i(tag_i), .flush_i(flush_i),
        .lane_valid_o(lane_valid_o), .lane_ready_i(lane_ready_i),
        .lane_out_valid_i(lane_out_valid_i), .lane_out_ready_o(lane_out_ready_o),
        .lane_result_i(lane_result_i), .lane_status_i(lane_status_i),
        .out_valid_o(out_valid_o), .out_ready_i(out_ready_i),
        .result_o(result_o), .status_o(status_o), .tag_o(tag_o), .busy_o(busy_o)
    );

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        n_cmp++;
        assert (obs === exp) else begin
            n_err++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    task automatic tick;
        @(posedge clk_i);
        #1;
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog expired observed=running expected=finished");
        $fatal(1, "watchdog");
    end

    initial begin
        rst_ni = 1'b0; in_valid_i = 1'b0; vectorial_op_i = 1'b0; simd_mask_i = 2'b00;
        box_bit_i = 1'b0; tag_i = 8'h00; flush_i = 1'b0; lane_ready_i = 2'b11;
        lane_out_valid_i = 2'b00; lane_result_i = '0; lane_status_i = '0; out_ready_i = 1'b0;
        repeat (2) @(posedge clk_i);
        #1;
        chk("rst_in_ready", in_ready_o, 1);
        chk("rst_lane_valid", lane_valid_o, 0);
        chk("rst_lane_out_ready", lane_out_ready_o, 0);
        chk("rst_out_valid", out_valid_o, 0);
        chk("rst_result", result_o, 0);
        chk("rst_status", status_o, 0);
        chk("rst_tag", tag_o, 0);
        chk("rst_busy", busy_o, 0);
        rst_ni = 1'b1;
        tick;

        // scalar op, NaN-boxed upper half
        in_valid_i = 1'b1; box_bit_i = 1'b1; tag_i = 8'h10; simd_mask_i = 2'b01;
        #1;
        chk("sc_lane_valid", lane_valid_o, 2'b01);
        chk("sc_in_ready", in_ready_o, 1);
        tick;
        in_valid_i = 1'b0;
        #1;
        chk("sc_busy", busy_o, 1);
        chk("sc_lane_out_ready", lane_out_ready_o, 2'b01);
        chk("sc_out_valid_early", out_valid_o, 0);
        tick;
        tick;
        lane_out_valid_i = 2'b01; lane_result_i = {32'h0, 32'h3F80_0000};
        #1;
        chk("sc_no_comb_valid", out_valid_o, 0);
        tick;
        lane_out_valid_i = 2'b00;
        #1;
        chk("sc_out_valid", out_valid_o, 1);
        chk("sc_result", result_o, 64'hFFFF_FFFF_3F80_0000);
        chk("sc_tag", tag_o, 8'h10);
        chk("sc_status", status_o, 0);
        chk("sc_lane_out_ready_done", lane_out_ready_o, 2'b00);
        tick;
        chk("sc_hold_valid", out_valid_o, 1);
        chk("sc_hold_result", result_o, 64'hFFFF_FFFF_3F80_0000);
        out_ready_i = 1'b1;
        tick;
        out_ready_i = 1'b0;
        #1;
        chk("sc_idle_busy", busy_o, 0);
        chk("sc_idle_valid", out_valid_o, 0);

        // skewed vector with masked status
        in_valid_i = 1'b1; vectorial_op_i = 1'b1; simd_mask_i = 2'b10; box_bit_i = 1'b0; tag_i = 8'h20;
        #1;
        chk("vec_lane_valid", lane_valid_o, 2'b11);
        tick;
        in_valid_i = 1'b0; vectorial_op_i = 1'b0;
        tick;
        lane_out_valid_i = 2'b10; lane_result_i = {32'h4000_0000, 32'hDEAD_BEEF};
        lane_status_i = {5'b00100, 5'b00000};
        tick;
        lane_out_valid_i = 2'b00;
        #1;
        chk("vec_lane1_ready_low", lane_out_ready_o, 2'b01);
        chk("vec_wait_lane0", out_valid_o, 0);
        tick;
        tick;
        lane_out_valid_i = 2'b01; lane_result_i = {32'h1234_5678, 32'h3F80_0000};
        lane_status_i = {5'b11111, 5'b00001};
        tick;
        lane_out_valid_i = 2'b00;
        #1;
        chk("vec_out_valid", out_valid_o, 1);
        chk("vec_result", result_o, 64'h4000_0000_3F80_0000);
        chk("vec_status", status_o, 5'b00100);
        chk("vec_tag", tag_o, 8'h20);
        out_ready_i = 1'b1;
        tick;
        out_ready_i = 1'b0;

        // partial lane readiness blocks a vector op
        lane_ready_i = 2'b01; vectorial_op_i = 1'b1; in_valid_i = 1'b1;
        #1;
        chk("pr_lane_valid", lane_valid_o, 2'b00);
        chk("pr_in_ready", in_ready_o, 0);
        tick;
        chk("pr_no_issue", busy_o, 0);
        lane_ready_i = 2'b11;
        #1;
        chk("pr_in_ready_both", in_ready_o, 1);
        chk("pr_lane_valid_both", lane_valid_o, 2'b11);
        in_valid_i = 1'b0; vectorial_op_i = 1'b0;

        // fill to Depth under backpressure
        simd_mask_i = 2'b01; box_bit_i = 1'b0;
        for (int i = 0; i < 4; i++) begin
            tag_i = 8'(i); in_valid_i = 1'b1;
            #1;
            chk("fill_in_ready", in_ready_o, 1);
            tick;
        end
        tag_i = 8'd4;
        #1;
        chk("full_in_ready", in_ready_o, 0);
        chk("full_lane_valid", lane_valid_o, 2'b00);
        chk("full_busy", busy_o, 1);
        lane_out_valid_i = 2'b01; lane_result_i = {32'h0, 32'hA0};
        tick;
        lane_out_valid_i = 2'b00;
        #1;
        chk("full_head_valid", out_valid_o, 1);
        chk("full_head_tag", tag_o, 0);
        chk("full_head_result", result_o, 64'hA0);
        out_ready_i = 1'b1;
        #1;
        chk("full_pop_no_ready", in_ready_o, 0);
        tick;
        out_ready_i = 1'b0;
        #1;
        chk("after_pop_in_ready", in_ready_o, 1);
        chk("after_pop_out_valid", out_valid_o, 0);
        tick;
        in_valid_i = 1'b0;
        #1;
        chk("refull_in_ready", in_ready_o, 0);
        for (int i = 1; i < 5; i++) begin
            lane_out_valid_i = 2'b01; lane_result_i = {32'h0, 32'hA0 + 32'(i)};
            tick;
            lane_out_valid_i = 2'b00; out_ready_i = 1'b1;
            #1;
            chk("drain_valid", out_valid_o, 1);
            chk("drain_tag", tag_o, 64'(i));
            chk("drain_result", result_o, 64'hA0 + 64'(i));
            tick;
            out_ready_i = 1'b0;
        end
        #1;
        chk("drain_idle", busy_o, 0);

        // push and pop in one cycle keep one op in flight
        tag_i = 8'h01; in_valid_i = 1'b1;
        tick;
        in_valid_i = 1'b0; lane_out_valid_i = 2'b01; lane_result_i = {32'h0, 32'h55};
        tick;
        lane_out_valid_i = 2'b00; tag_i = 8'h02; in_valid_i = 1'b1; out_ready_i = 1'b1;
        tick;
        in_valid_i = 1'b0; out_ready_i = 1'b0;
        #1;
        chk("pp_busy", busy_o, 1);
        chk("pp_tag", tag_o, 8'h02);
        chk("pp_out_valid", out_valid_o, 0);
        chk("pp_in_ready", in_ready_o, 1);
        lane_out_valid_i = 2'b01;
        tick;
        lane_out_valid_i = 2'b00; out_ready_i = 1'b1;
        tick;
        out_ready_i = 1'b0;
        #1;
        chk("pp_idle", busy_o, 0);

        // flush with three ops in flight
        for (int i = 0; i < 3; i++) begin
            tag_i = 8'(7 + i); in_valid_i = 1'b1;
            tick;
        end
        in_valid_i = 1'b0;
        lane_out_valid_i = 2'b01; lane_result_i = {32'h0, 32'h77};
        tick;
        lane_out_valid_i = 2'b00;
        #1;
        chk("fl_head_done", out_valid_o, 1);
        flush_i = 1'b1; lane_out_valid_i = 2'b01;
        #1;
        chk("fl_out_valid", out_valid_o, 0);
        chk("fl_in_ready", in_ready_o, 0);
        chk("fl_drain_ready", lane_out_ready_o, 2'b11);
        tick;
        flush_i = 1'b0; lane_out_valid_i = 2'b00;
        #1;
        chk("fl_busy", busy_o, 0);
        chk("fl_out_valid_after", out_valid_o, 0);
        chk("fl_lane_out_ready_after", lane_out_ready_o, 2'b00);
        tag_i = 8'h5E; box_bit_i = 1'b1; in_valid_i = 1'b1;
        tick;
        in_valid_i = 1'b0; lane_out_valid_i = 2'b01; lane_result_i = {32'h0, 32'h1111_1111};
        tick;
        lane_out_valid_i = 2'b00;
        #1;
        chk("pf_valid", out_valid_o, 1);
        chk("pf_tag", tag_o, 8'h5E);
        chk("pf_result", result_o, 64'hFFFF_FFFF_1111_1111);
        out_ready_i = 1'b1;
        tick;
        out_ready_i = 1'b0;

        // asynchronous reset mid-operation
        tag_i = 8'h03; in_valid_i = 1'b1;
        tick;
        in_valid_i = 1'b0;
        #1;
        chk("ar_busy_before", busy_o, 1);
        rst_ni = 1'b0;
        #1;
        chk("ar_busy", busy_o, 0);
        chk("ar_lane_out_ready", lane_out_ready_o, 2'b00);
        chk("ar_tag", tag_o, 0);
        #2;
        rst_ni = 1'b1;
        tick;

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
